// File: rtl/mask_pkg.sv
// Shared types and helpers for the multiplier operand-preparation stage.
//   operand_pair_t : one masked operand pair as presented to the multiplier
//   skid_state_e   : occupancy of the two-entry skid buffer
//   apply_mask     : logical right shift of a raw operand
//   mask_lost      : OR of the bits discarded by that shift
package mask_pkg;

  localparam int MASK_W     = 64;  // widest operand the helpers accept
  localparam int PAIR_OUT_W = 32;  // multiplier operand width

  typedef struct packed {
    logic [PAIR_OUT_W-1:0] a;
    logic [PAIR_OUT_W-1:0] b;
    logic                  lost;
  } operand_pair_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  function automatic logic [MASK_W-1:0] apply_mask(input logic [MASK_W-1:0] x,
                                                   input int unsigned       shift);
    return x >> shift;
  endfunction

  // A zero shift gives an all-zero mask, so nothing is ever reported lost.
  function automatic logic mask_lost(input logic [MASK_W-1:0] x,
                                     input int unsigned       shift);
    logic [MASK_W-1:0] low_mask;
    low_mask = (MASK_W'(1) << shift) - MASK_W'(1);
    return |(x & low_mask);
  endfunction

endpackage

// File: rtl/mask_operand_stage.sv
// Registered operand-preparation stage feeding the 32-bit multiplier.
// Each accepted raw pair is right-shifted by SHIFT, zero-extended to OUT_W
// and held in a two-entry skid buffer so back-pressure never drops data.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     upstream handshake
//   in_a, in_b            raw operands (IN_W)
//   out_valid/out_ready   downstream handshake
//   out_a, out_b          masked, zero-extended operands (OUT_W)
//   out_lost              non-zero bits were shifted out of this pair
//   xfer_count            pairs delivered since reset (wraps)
//
// state | meaning
// EMPTY | no pair held, outputs invalid
// ONE   | main register holds the head pair
// TWO   | main and skid both full, upstream stalled
module mask_operand_stage
  import mask_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHIFT = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_a,
  input  logic [IN_W-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_a,
  output logic [OUT_W-1:0] out_b,
  output logic             out_lost,
  output logic [CNT_W-1:0] xfer_count
);

  typedef struct packed {
    logic [OUT_W-1:0] a;
    logic [OUT_W-1:0] b;
    logic             lost;
  } pair_t;

  skid_state_e state_q, state_d;
  pair_t       main_q, skid_q, in_pair;
  logic        accept, deliver;
  logic        load_main, load_skid, main_from_skid;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;

  always_comb begin
    in_pair.a    = OUT_W'(apply_mask(MASK_W'(in_a), SHIFT));
    in_pair.b    = OUT_W'(apply_mask(MASK_W'(in_b), SHIFT));
    in_pair.lost = mask_lost(MASK_W'(in_a), SHIFT) || mask_lost(MASK_W'(in_b), SHIFT);
  end

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (accept && !deliver) begin
          load_skid = 1'b1;
          state_d   = TWO;
        end else if (accept && deliver) begin
          load_main = 1'b1;
        end else if (deliver) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (deliver) begin
          main_from_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Registers load only on accept, so undefined inputs in idle cycles never reach them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      xfer_count <= '0;
    end else begin
      state_q <= state_d;
      if (load_main)           main_q <= in_pair;
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_pair;
      if (deliver)             xfer_count <= xfer_count + CNT_W'(1);
    end
  end

  assign out_a    = main_q.a;
  assign out_b    = main_q.b;
  assign out_lost = main_q.lost;

endmodule
